// File: rtl/md_issue_pkg.sv
// Shared constants for the multiply/divide issue controller: FSM states,
// HI/LO read-select codes and operand width.
package md_issue_pkg;

   localparam int unsigned OPW = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [1:0] SEL_NONE = 2'b00;
   localparam logic [1:0] SEL_HI   = 2'b01;
   localparam logic [1:0] SEL_LO   = 2'b10;

endpackage

// File: rtl/md_issue.sv
// Issue controller between the pipeline and a multi-cycle MD unit; keeps local HI/LO copies.
// Optional WAIT timeout with sticky err is enabled by defining MD_TIMEOUT_EN.
module md_issue
   import md_issue_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           req_valid,
   input  logic           req_div,
   input  logic [OPW-1:0] req_a,
   input  logic [OPW-1:0] req_b,
   input  logic [1:0]     rd_sel,
   input  logic           wr_hi,
   input  logic           wr_lo,
   input  logic [OPW-1:0] wr_data,
   output logic [OPW-1:0] D1,
   output logic [OPW-1:0] D2,
   output logic           Start,
   output logic           MD,
   input  logic           Busy,
   input  logic [OPW-1:0] HI,
   input  logic [OPW-1:0] LO,
   output logic           stall,
   output logic [OPW-1:0] rd_data,
   output logic           err
);

   state_t         r_state;
   state_t         w_state_nx;
   logic [OPW-1:0] r_d1;
   logic [OPW-1:0] r_d2;
   logic [OPW-1:0] r_hi;
   logic [OPW-1:0] r_lo;
   logic           r_md;
   logic           r_grace;
   logic           w_any;
   logic           w_accept;
   logic           w_capture;
   logic           w_expire;
   logic           w_start;
   logic           w_wr_ok;

   assign w_any     = req_valid | (rd_sel != SEL_NONE) | wr_hi | wr_lo;
   assign w_accept  = (r_state == IDLE) && req_valid && !Busy;
   assign w_capture = (r_state == WAIT) && !r_grace && !Busy;
   assign stall     = (r_state == IDLE) ? (req_valid & Busy) : w_any;
   assign w_wr_ok   = (r_state == IDLE) && !stall;

`ifdef MD_TIMEOUT_EN
   localparam int unsigned CW = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);

   logic [CW-1:0] r_cnt;
   logic          r_err;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt <= '0;
         r_err <= 1'b0;
      end else begin
         if (r_state == ISSUE)
            r_cnt <= '0;
         else if (r_state == WAIT)
            r_cnt <= r_cnt + CW'(1);
         if (w_expire)
            r_err <= 1'b1;
      end
   end

   // A normal completion in the same cycle takes priority over expiry.
   assign w_expire = (r_state == WAIT) && !w_capture && ((r_cnt + CW'(1)) == CW'(TIMEOUT));
   assign err      = r_err;
`else
   assign w_expire = 1'b0;
   assign err      = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset)
         r_state <= IDLE;
      else
         r_state <= w_state_nx;
   end

   // ISSUE holds (Start withheld) while the unit still reports Busy.
   always_comb begin
      w_state_nx = r_state;
      w_start    = 1'b0;
      case (r_state)
         IDLE:  if (w_accept) w_state_nx = ISSUE;
         ISSUE: if (!Busy) begin
                   w_start    = 1'b1;
                   w_state_nx = WAIT;
                end
         WAIT:  if (w_capture || w_expire) w_state_nx = DONE;
         DONE:  w_state_nx = IDLE;
         default: w_state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_d1    <= '0;
         r_d2    <= '0;
         r_md    <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_grace <= 1'b0;
      end else begin
         r_grace <= w_start;
         if (w_accept) begin
            r_d1 <= req_a;
            r_d2 <= req_b;
            r_md <= req_div;
         end
         if (w_wr_ok) begin
            if (wr_hi) r_hi <= wr_data;
            if (wr_lo) r_lo <= wr_data;
         end
         if (w_capture) begin
            r_hi <= HI;
            r_lo <= LO;
         end
      end
   end

   always_comb begin
      rd_data = '0;
      case (rd_sel)
         SEL_HI:  rd_data = r_hi;
         SEL_LO:  rd_data = r_lo;
         default: rd_data = '0;
      endcase
   end

   assign D1    = r_d1;
   assign D2    = r_d2;
   assign MD    = r_md;
   assign Start = w_start;

endmodule
